ex_resolve: RTL and testbench

Execute-stage resolve and output buffer, directly downstream of the ALU. Each cycle it accepts one decoded instruction together with the ALU's `eval`/`zero` result, resolves branches and jumps, discards wrong-path instructions by epoch tag, and emits a one-cycle redirect to fetch. Surviving results are buffered in a 2-entry FIFO with a valid/ready handshake toward the memory stage.

---
 rtl/ex_resolve_if.sv | 47 ++++
 rtl/ex_resolve.sv | 123 ++++++++++++
 tb/tb_ex_resolve.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_resolve_if.sv
// Purpose: bundle of the execute-resolve handshake and result signals.
//   Upstream  : in_valid/in_ready plus the decoded instruction and ALU result.
//   Downstream: out_valid/out_ready plus writeback result, rd and write enable.
//   Fetch     : redirect_valid/redirect_pc pulse and the current epoch.
// Modports: master = environment driving instructions and consuming results,
//           slave  = the ex_resolve block.
interface ex_resolve_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_pc;
    logic [DATA_W-1:0]     in_imm;
    logic [DATA_W-1:0]     in_eval;
    logic                  in_zero;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_reg_wr;
    logic                  in_is_branch;
    logic                  in_is_jal;
    logic                  in_is_jalr;
    logic                  in_epoch;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_result;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_reg_wr;

    logic                  redirect_valid;
    logic [DATA_W-1:0]     redirect_pc;
    logic                  epoch;

    modport master (
        output in_valid, in_pc, in_imm, in_eval, in_zero, in_rd, in_reg_wr,
               in_is_branch, in_is_jal, in_is_jalr, in_epoch, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_reg_wr,
               redirect_valid, redirect_pc, epoch
    );

    modport slave (
        input  in_valid, in_pc, in_imm, in_eval, in_zero, in_rd, in_reg_wr,
               in_is_branch, in_is_jal, in_is_jalr, in_epoch, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_reg_wr,
               redirect_valid, redirect_pc, epoch
    );
endinterface

// File: rtl/ex_resolve.sv
// Purpose: execute-stage resolve. Resolves branches/jumps, drops wrong-path
// instructions by epoch tag, pulses a one-cycle fetch redirect and buffers
// surviving results in a 2-entry FIFO toward the memory stage.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - ex_resolve_if.slave: instruction in, result out, redirect/epoch
module ex_resolve #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    ex_resolve_if.slave  bus
);
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2);

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_wr;
    } entry_t;

    entry_t             mem_q [2];
    logic               head_q, head_d;
    logic               tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               epoch_q, epoch_d;
    logic               redir_valid_q, redir_valid_d;
    logic [DATA_W-1:0]  redir_pc_q, redir_pc_d;

    logic               accept_c;
    logic               live_c;
    logic               is_jump_c;
    logic               redirect_c;
    logic               push_c;
    logic               pop_c;
    logic [DATA_W-1:0]  target_c;
    entry_t             push_entry_c;

    // Ready depends only on registered occupancy
    assign bus.in_ready   = (count_q != CNT_FULL);
    assign bus.out_valid  = (count_q != CNT_W'(0));
    assign bus.out_result = mem_q[head_q].result;
    assign bus.out_rd     = mem_q[head_q].rd;
    assign bus.out_reg_wr = mem_q[head_q].reg_wr;

    assign bus.redirect_valid = redir_valid_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.epoch          = epoch_q;

    // Resolve: wrong-epoch instructions are consumed but have no effect
    always_comb begin
        accept_c   = bus.in_valid && bus.in_ready;
        live_c     = accept_c && (bus.in_epoch == epoch_q);
        is_jump_c  = bus.in_is_jal || bus.in_is_jalr;
        // ALU outputs 1 when the branch condition holds, so non-zero = taken
        redirect_c = live_c && (is_jump_c || (bus.in_is_branch && !bus.in_zero));
        push_c     = live_c && !bus.in_is_branch;
        pop_c      = bus.out_valid && bus.out_ready;

        target_c = bus.in_is_jalr
                 ? (bus.in_eval & {{(DATA_W-1){1'b1}}, 1'b0})
                 : (bus.in_pc + bus.in_imm);

        push_entry_c.result = is_jump_c ? (bus.in_pc + DATA_W'(4)) : bus.in_eval;
        push_entry_c.rd     = bus.in_rd;
        // x0 is never written regardless of the decoded write enable
        push_entry_c.reg_wr = bus.in_reg_wr && (bus.in_rd != REG_ADDR_W'(0));
    end

    // Next-state for FIFO pointers, occupancy, epoch and redirect pulse
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        epoch_d       = epoch_q;
        redir_valid_d = redirect_c;
        redir_pc_d    = redir_pc_q;

        if (push_c) begin
            tail_d = ~tail_q;
        end
        if (pop_c) begin
            head_d = ~head_q;
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (redirect_c) begin
            redir_pc_d = target_c;
            epoch_d    = ~epoch_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            count_q       <= '0;
            epoch_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            mem_q[0]      <= '0;
            mem_q[1]      <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            epoch_q       <= epoch_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            if (push_c) begin
                mem_q[tail_q] <= push_entry_c;
            end
        end
    end
endmodule

// File: tb/tb_ex_resolve.sv
// Bench for ex_resolve: vector table for single-instruction behaviour plus
// hand-written backpressure, concurrent push/pop and mid-stream reset runs.
// Expected FIFO outputs go through a scoreboard queue.
module tb_ex_resolve;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic clk;
    logic rst;

    ex_resolve_if #(.DATA_W(DW), .REG_ADDR_W(RW)) bus ();

    ex_resolve #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] result;
        logic [RW-1:0] rd;
        logic          wr;
    } exp_t;

    typedef struct {
        logic          valid;
        logic          stale;
        logic          br;
        logic          jal;
        logic          jalr;
        logic [DW-1:0] pc;
        logic [DW-1:0] imm;
        logic [DW-1:0] eval;
        logic          zero;
        logic [RW-1:0] rd;
        logic          wr;
        logic          exp_push;
        logic [DW-1:0] exp_res;
        logic [RW-1:0] exp_rd;
        logic          exp_wr;
        logic          exp_redir;
        logic [DW-1:0] exp_rpc;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   checks;
    int   errors;
    logic m_epoch;

    function automatic vec_t mk(logic valid, logic stale, logic br, logic jal, logic jalr,
                                logic [DW-1:0] pc, logic [DW-1:0] imm, logic [DW-1:0] eval,
                                logic zero, logic [RW-1:0] rd, logic wr,
                                logic exp_push, logic [DW-1:0] exp_res, logic [RW-1:0] exp_rd,
                                logic exp_wr, logic exp_redir, logic [DW-1:0] exp_rpc);
        vec_t v;
        v.valid = valid; v.stale = stale; v.br = br; v.jal = jal; v.jalr = jalr;
        v.pc = pc; v.imm = imm; v.eval = eval; v.zero = zero; v.rd = rd; v.wr = wr;
        v.exp_push = exp_push; v.exp_res = exp_res; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
        v.exp_redir = exp_redir; v.exp_rpc = exp_rpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample the FIFO head just before the edge that pops it, then step one cycle
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got result %h with empty scoreboard", bus.out_result);
            end else begin
                e = sb.pop_front();
                chk("pop_result", bus.out_result, e.result);
                chk("pop_rd", DW'(bus.out_rd), DW'(e.rd));
                chk("pop_reg_wr", DW'(bus.out_reg_wr), DW'(e.wr));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_imm = '0; bus.in_eval = '0;
        bus.in_zero = 1'b0; bus.in_rd = '0; bus.in_reg_wr = 1'b0; bus.in_is_branch = 1'b0;
        bus.in_is_jal = 1'b0; bus.in_is_jalr = 1'b0; bus.in_epoch = 1'b0;
    endtask

    task automatic drive_alu(input logic [DW-1:0] val, input logic [RW-1:0] rd);
        drive_idle();
        bus.in_valid = 1'b1; bus.in_eval = val; bus.in_rd = rd; bus.in_reg_wr = 1'b1;
        bus.in_epoch = m_epoch;
    endtask

    task automatic push_exp(input logic [DW-1:0] r, input logic [RW-1:0] rd, input logic wr);
        exp_t e;
        e.result = r; e.rd = rd; e.wr = wr;
        sb.push_back(e);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_epoch = 1'b0;
        rst     = 1'b1;
        drive_idle();
        bus.out_ready = 1'b1;

        //            v  st br jal jalr pc            imm           eval          z  rd  wr  push res           rd  wr redir rpc
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_00AB, 0, 5,  1,  1, 32'h0000_00AB, 5,  1, 0, 32'h0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_1234, 0, 0,  1,  1, 32'h0000_1234, 0,  0, 0, 32'h0);
        vecs[2]  = mk(1, 0, 1, 0, 0, 32'h100,      32'hFFFF_FFF0, 32'h1,        0, 0,  0,  0, 32'h0,         0,  0, 1, 32'h0000_00F0);
        vecs[3]  = mk(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0055, 0, 3,  1,  0, 32'h0,         0,  0, 0, 32'h0);
        vecs[4]  = mk(1, 0, 0, 0, 1, 32'h200,      32'h0,        32'h0000_1235, 0, 1,  1,  1, 32'h0000_0204, 1,  1, 1, 32'h0000_1234);
        vecs[5]  = mk(1, 0, 1, 0, 0, 32'h300,      32'h8,        32'h0,         1, 0,  0,  0, 32'h0,         0,  0, 0, 32'h0);
        vecs[6]  = mk(1, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h10,      32'h0,         0, 2,  1,  1, 32'h0,         2,  1, 1, 32'h0000_000C);
        vecs[7]  = mk(1, 0, 0, 1, 0, 32'h400,      32'h20,       32'h0,         0, 0,  1,  1, 32'h0000_0404, 0,  0, 1, 32'h0000_0420);
        vecs[8]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0099, 0, 4,  1,  0, 32'h0,         0,  0, 0, 32'h0);
        vecs[9]  = mk(1, 1, 0, 0, 1, 32'h600,      32'h0,        32'h0000_0800, 0, 6,  1,  0, 32'h0,         0,  0, 0, 32'h0);
        vecs[10] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFF, 0, 31, 0,  1, 32'hFFFF_FFFF, 31, 0, 0, 32'h0);

        // Reset values
        #12;
        chk("rst_out_valid", DW'(bus.out_valid), 32'h0);
        chk("rst_out_result", bus.out_result, 32'h0);
        chk("rst_out_rd", DW'(bus.out_rd), 32'h0);
        chk("rst_out_reg_wr", DW'(bus.out_reg_wr), 32'h0);
        chk("rst_redirect_valid", DW'(bus.redirect_valid), 32'h0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
        chk("rst_epoch", DW'(bus.epoch), 32'h0);
        chk("rst_in_ready", DW'(bus.in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: one instruction per cycle, downstream always ready
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("v%0d_in_ready", i), DW'(bus.in_ready), 32'h1);
            drive_idle();
            bus.in_valid     = vecs[i].valid;
            bus.in_is_branch = vecs[i].br;
            bus.in_is_jal    = vecs[i].jal;
            bus.in_is_jalr   = vecs[i].jalr;
            bus.in_pc        = vecs[i].pc;
            bus.in_imm       = vecs[i].imm;
            bus.in_eval      = vecs[i].eval;
            bus.in_zero      = vecs[i].zero;
            bus.in_rd        = vecs[i].rd;
            bus.in_reg_wr    = vecs[i].wr;
            bus.in_epoch     = vecs[i].stale ? ~m_epoch : m_epoch;
            if (vecs[i].exp_push) push_exp(vecs[i].exp_res, vecs[i].exp_rd, vecs[i].exp_wr);
            cycle();
            if (vecs[i].exp_redir) m_epoch = ~m_epoch;
            chk($sformatf("v%0d_redirect_valid", i), DW'(bus.redirect_valid), DW'(vecs[i].exp_redir));
            chk($sformatf("v%0d_epoch", i), DW'(bus.epoch), DW'(m_epoch));
            chk($sformatf("v%0d_out_valid", i), DW'(bus.out_valid), DW'(vecs[i].exp_push));
            if (vecs[i].exp_redir)
                chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].exp_rpc);
        end
        drive_idle();
        cycle();
        chk("pulse_one_cycle", DW'(bus.redirect_valid), 32'h0);
        cycle();

        // Backpressure: two fill the FIFO, third is held until space frees
        bus.out_ready = 1'b0;
        drive_alu(32'h0000_0001, 5'd1);
        push_exp(32'h0000_0001, 5'd1, 1'b1);
        cycle();
        drive_alu(32'h0000_0002, 5'd2);
        push_exp(32'h0000_0002, 5'd2, 1'b1);
        cycle();
        chk("bp_in_ready_full", DW'(bus.in_ready), 32'h0);
        drive_alu(32'h0000_0003, 5'd3);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("bp_hold%0d_in_ready", k), DW'(bus.in_ready), 32'h0);
            chk($sformatf("bp_hold%0d_result", k), bus.out_result, 32'h0000_0001);
            chk($sformatf("bp_hold%0d_rd", k), DW'(bus.out_rd), 32'h1);
        end
        bus.out_ready = 1'b1;
        begin
            bit accepted = 1'b0;
            for (int k = 0; k < 10 && !accepted; k++) begin
                if (bus.in_ready) begin
                    push_exp(32'h0000_0003, 5'd3, 1'b1);
                    accepted = 1'b1;
                end
                cycle();
            end
            checks++;
            if (!accepted) begin
                errors++;
                $display("FAIL bp_third_accept: got not accepted expected accepted within 10 cycles");
            end
        end
        drive_idle();
        repeat (4) cycle();
        chk("bp_drained", DW'(sb.size()), 32'h0);

        // Concurrent push/pop at count 1 across several pointer wraps
        for (int k = 0; k < 9; k++) begin
            drive_alu(32'h0000_1000 + DW'(k), RW'(k + 1));
            push_exp(32'h0000_1000 + DW'(k), RW'(k + 1), 1'b1);
            cycle();
            chk($sformatf("cc%0d_out_valid", k), DW'(bus.out_valid), 32'h1);
            chk($sformatf("cc%0d_in_ready", k), DW'(bus.in_ready), 32'h1);
        end
        drive_idle();
        repeat (3) cycle();
        chk("cc_drained", DW'(sb.size()), 32'h0);

        // Mid-stream reset with two entries buffered and a redirect pending
        bus.out_ready = 1'b0;
        drive_alu(32'h0000_0077, 5'd7);
        push_exp(32'h0000_0077, 5'd7, 1'b1);
        cycle();
        drive_idle();
        bus.in_valid = 1'b1; bus.in_is_jal = 1'b1; bus.in_pc = 32'h500; bus.in_imm = 32'h40;
        bus.in_rd = 5'd1; bus.in_reg_wr = 1'b1; bus.in_epoch = m_epoch;
        push_exp(32'h0000_0504, 5'd1, 1'b1);
        cycle();
        m_epoch = ~m_epoch;
        chk("mr_pre_redirect", DW'(bus.redirect_valid), 32'h1);
        chk("mr_pre_in_ready", DW'(bus.in_ready), 32'h0);
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        chk("mr_out_valid", DW'(bus.out_valid), 32'h0);
        chk("mr_out_result", bus.out_result, 32'h0);
        chk("mr_out_rd", DW'(bus.out_rd), 32'h0);
        chk("mr_out_reg_wr", DW'(bus.out_reg_wr), 32'h0);
        chk("mr_redirect_valid", DW'(bus.redirect_valid), 32'h0);
        chk("mr_redirect_pc", bus.redirect_pc, 32'h0);
        chk("mr_in_ready", DW'(bus.in_ready), 32'h1);
        chk("mr_epoch", DW'(bus.epoch), 32'h0);
        sb.delete();
        m_epoch = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Post-reset sanity: fresh instruction flows with epoch 0
        drive_alu(32'h0000_00C3, 5'd9);
        push_exp(32'h0000_00C3, 5'd9, 1'b1);
        cycle();
        chk("post_rst_out_valid", DW'(bus.out_valid), 32'h1);
        drive_idle();
        repeat (3) cycle();
        chk("final_drained", DW'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
